// File: rtl/pc_seq_ctrl_pkg.sv
// rtl/pc_seq_ctrl_pkg.sv - shared types and constants for the pc sequencer
package pc_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_FETCH = 2'd1,
        ST_REDIR = 2'd2
    } pc_state_e;

    localparam int STALL_W = 6;

    // Per-stage hold masks: bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_IMEM = 6'b000011;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Fetch targets are always word aligned
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_seq_ctrl_stall.sv
// rtl/pc_seq_ctrl_stall.sv - combinational per-stage stall encoder
//
// Ports:
//   flush         exception flush (wins over everything, releases all stages)
//   stall_req_ex  execute stage stall request
//   stall_req_id  decode stage stall request
//   ce            fetch request outstanding
//   imem_ack      instruction memory acknowledge
//   stall         per-stage hold mask
import pc_seq_ctrl_pkg::*;

module stall_ctrl (
    input  logic               flush,
    input  logic               stall_req_ex,
    input  logic               stall_req_id,
    input  logic               ce,
    input  logic               imem_ack,
    output logic [STALL_W-1:0] stall
);

    always_comb begin
        stall = STALL_NONE;
        if (flush) begin
            stall = STALL_NONE;
        end else if (stall_req_ex) begin
            stall = STALL_EX;
        end else if (stall_req_id) begin
            stall = STALL_ID;
        end else if (ce && !imem_ack) begin
            stall = STALL_IMEM;
        end
    end

endmodule

// File: rtl/pc_seq_ctrl.sv
// rtl/pc_seq_ctrl.sv - program counter sequencer with fetch handshake and redirect
//
// Parameters:
//   RESET_PC       first fetch address after reset (low two bits ignored)
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   stall_req_id   decode stall request
//   stall_req_ex   execute stall request
//   branch_flag    decode resolved a taken branch/jump
//   branch_target  branch/jump destination
//   flush          exception flush, highest priority
//   new_pc         exception handler address
//   imem_ack       instruction memory returns the word for pc
//   pc             fetch address
//   ce             fetch request / imem enable
//   inst_valid     returned word is on the current program path
//   stall          per-stage hold mask
import pc_seq_ctrl_pkg::*;

module pc_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_req_id,
    input  logic               stall_req_ex,
    input  logic               branch_flag,
    input  logic [31:0]        branch_target,
    input  logic               flush,
    input  logic [31:0]        new_pc,
    input  logic               imem_ack,
    output logic [31:0]        pc,
    output logic               ce,
    output logic               inst_valid,
    output logic [STALL_W-1:0] stall
);

    pc_state_e    state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  redir_q, redir_d;
    logic         boot_q, boot_d;
    logic         branch_ok;
    logic         any_stall;
    logic [31:0]  flush_tgt;
    logic [31:0]  branch_tgt;
    logic [31:0]  redir_eff;
    logic [STALL_W-1:0] stall_raw;

    // A branch presented together with any stall is dropped; decode re-presents it
    assign any_stall  = stall_req_id | stall_req_ex;
    assign branch_ok  = branch_flag & ~any_stall;
    assign flush_tgt  = word_align(new_pc);
    assign branch_tgt = word_align(branch_target);

    // While waiting for the stale ack, a later flush replaces the pending target
    assign redir_eff  = flush ? flush_tgt : redir_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        redir_d = redir_q;
        boot_d  = boot_q;
        case (state_q)
            ST_OFF: begin
                pc_d = word_align(RESET_PC);
                // Spend one full cycle with rst low in OFF before fetching
                if (boot_q) begin
                    boot_d = 1'b0;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    if (flush) begin
                        pc_d = flush_tgt;
                    end else if (branch_ok) begin
                        pc_d = branch_tgt;
                    end else if (!any_stall) begin
                        pc_d = pc_q + PC_STEP;
                    end
                end else if (flush) begin
                    // The word in flight is for the old path; remember where to go
                    redir_d = flush_tgt;
                    state_d = ST_REDIR;
                end else if (branch_ok) begin
                    redir_d = branch_tgt;
                    state_d = ST_REDIR;
                end
            end
            ST_REDIR: begin
                redir_d = redir_eff;
                if (imem_ack) begin
                    pc_d    = redir_eff;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OFF;
            pc_q    <= word_align(RESET_PC);
            redir_q <= 32'h0000_0000;
            boot_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            redir_q <= redir_d;
            boot_q  <= boot_d;
        end
    end

    assign pc         = pc_q;
    assign ce         = (state_q != ST_OFF);
    assign inst_valid = ~rst & imem_ack & (state_q == ST_FETCH) & ~flush;

    stall_ctrl u_stall_ctrl (
        .flush        (flush),
        .stall_req_ex (stall_req_ex),
        .stall_req_id (stall_req_id),
        .ce           (ce),
        .imem_ack     (imem_ack),
        .stall        (stall_raw)
    );

    assign stall = rst ? STALL_NONE : stall_raw;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb/tb_pc_seq_ctrl.sv - self-checking bench for pc_seq_ctrl
module tb_pc_seq_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_req_id;
    logic        stall_req_ex;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        flush;
    logic [31:0] new_pc;
    logic        imem_ack;
    logic [31:0] pc;
    logic        ce;
    logic        inst_valid;
    logic [5:0]  stall;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    pc_seq_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_req_id  (stall_req_id),
        .stall_req_ex  (stall_req_ex),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .flush         (flush),
        .new_pc        (new_pc),
        .imem_ack      (imem_ack),
        .pc            (pc),
        .ce            (ce),
        .inst_valid    (inst_valid),
        .stall         (stall)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: fetching flag, a pending redirect flag + its target,
    // the current pc, and a one-cycle warm-up after reset release.
    bit          m_on;
    bit          m_pending;
    bit          m_warm;
    logic [31:0] m_tgt;
    logic [31:0] m_pc;

    always @(posedge clk) begin
        logic [31:0] fl_t, br_t, t;
        bit take;
        fl_t = new_pc & 32'hFFFF_FFFC;
        br_t = branch_target & 32'hFFFF_FFFC;
        if (rst) begin
            m_on = 0; m_pending = 0; m_warm = 1; m_tgt = 0;
            m_pc = RST_PC & 32'hFFFF_FFFC;
        end else if (!m_on) begin
            if (m_warm) m_warm = 0;
            else        m_on   = 1;
        end else if (m_pending) begin
            t = flush ? fl_t : m_tgt;
            if (imem_ack) begin m_pc = t; m_pending = 0; end
            else m_tgt = t;
        end else begin
            take = flush || (branch_flag && !stall_req_id && !stall_req_ex);
            t = flush ? fl_t : br_t;
            if (imem_ack) begin
                if (take) m_pc = t;
                else if (!(stall_req_id || stall_req_ex)) m_pc = m_pc + 32'd4;
            end else if (take) begin
                m_pending = 1; m_tgt = t;
            end
        end
    end

    always @(negedge clk) begin
        logic [5:0] e_stall;
        logic       e_valid;
        if (chk_en) begin
            e_valid = !rst && imem_ack && m_on && !m_pending && !flush;
            if (rst || flush)             e_stall = 6'b000000;
            else if (stall_req_ex)        e_stall = 6'b001111;
            else if (stall_req_id)        e_stall = 6'b000111;
            else if (m_on && !imem_ack)   e_stall = 6'b000011;
            else                          e_stall = 6'b000000;
            chk("cmp_pc",    pc,               m_pc);
            chk("cmp_ce",    {31'd0, ce},      {31'd0, m_on});
            chk("cmp_valid", {31'd0, inst_valid}, {31'd0, e_valid});
            chk("cmp_stall", {26'd0, stall},   {26'd0, e_stall});
        end
    end

    task automatic set_in(input logic r, input logic id, input logic ex, input logic br,
                          input logic [31:0] bt, input logic fl, input logic [31:0] np,
                          input logic ack);
        rst = r; stall_req_id = id; stall_req_ex = ex; branch_flag = br;
        branch_target = bt; flush = fl; new_pc = np; imem_ack = ack;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        set_in(1, 0, 0, 0, 0, 0, 0, 1);
        tick();
        chk_en = 1'b1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_ce", {31'd0, ce}, 32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_stall", {26'd0, stall}, 32'd0);
        tick();

        // release reset with ack tied high
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        chk("rel_ce0", {31'd0, ce}, 32'd0);
        tick();
        chk("off_ce0", {31'd0, ce}, 32'd0);
        tick();
        chk("first_ce", {31'd0, ce}, 32'd1);
        chk("seq_pc0", pc, 32'h0);
        chk("seq_valid0", {31'd0, inst_valid}, 32'd1);
        tick();
        chk("seq_pc4", pc, 32'h4);
        tick();
        chk("seq_pc8", pc, 32'h8);

        // execute stall holds pc for two cycles
        set_in(0, 0, 1, 0, 0, 0, 0, 1);
        chk("ex_stall", {26'd0, stall}, 32'h0F);
        tick();
        chk("ex_hold1", pc, 32'h8);
        tick();
        chk("ex_hold2", pc, 32'h8);
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        chk("ex_resume", pc, 32'hC);

        // branch without ack -> redirect, stale ack discarded
        set_in(0, 0, 0, 1, 32'h40, 0, 0, 0);
        chk("imem_stall", {26'd0, stall}, 32'h03);
        tick();
        chk("redir_hold", pc, 32'hC);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        chk("stale_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        chk("redir_pc", pc, 32'h40);
        chk("redir_valid", {31'd0, inst_valid}, 32'd1);

        // flush beats branch in the same cycle
        set_in(0, 0, 0, 1, 32'h40, 1, 32'h180, 1);
        chk("flush_stall", {26'd0, stall}, 32'h0);
        chk("flush_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        chk("flush_pc", pc, 32'h180);

        // branch with decode stall is not taken; unaligned target is aligned
        set_in(0, 1, 0, 1, 32'h1003, 0, 0, 1);
        chk("id_stall", {26'd0, stall}, 32'h07);
        tick();
        chk("br_blocked", pc, 32'h180);
        set_in(0, 0, 0, 1, 32'h1003, 0, 0, 1);
        tick();
        chk("br_aligned", pc, 32'h1000);

        // wrap-around
        set_in(0, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, 1);
        tick();
        chk("wrap_top", pc, 32'hFFFF_FFFC);
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        chk("wrap_zero", pc, 32'h0);

        // in redirect: flush overwrites target, branch ignored, flush on ack cycle wins
        set_in(0, 0, 0, 1, 32'h200, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 1, 32'h500, 1, 32'h300, 0);
        tick();
        chk("redir_wait", pc, 32'h0);
        set_in(0, 0, 0, 0, 0, 1, 32'h406, 1);
        chk("redir_fl_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        chk("redir_fl_pc", pc, 32'h404);
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        chk("after_redir", pc, 32'h408);

        // reset while redirect pending
        set_in(0, 0, 0, 1, 32'h700, 0, 0, 0);
        tick();
        set_in(1, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_in_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_in_stall", {26'd0, stall}, 32'd0);
        tick();
        chk("rst_redir_pc", pc, 32'h0);
        chk("rst_redir_ce", {31'd0, ce}, 32'd0);
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        chk("rst2_ce0", {31'd0, ce}, 32'd0);
        tick();
        chk("rst2_ce1", {31'd0, ce}, 32'd1);
        chk("rst2_pc", pc, 32'h0);
        tick();
        chk("rst2_pc4", pc, 32'h4);

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
